exe_muldiv: RTL and testbench
=============================

Name: exe_muldiv

Overview:
- Parametrised iterative multiply/divide execute unit; implements the RV64M / RV32M operations alongside the combinational integer ALU in the EXE stage.
- Accepts one operation per valid/ready handshake and computes it over multiple cycles.
- Holds the result until the consumer accepts it; the pipeline stalls on in_ready_o / busy_o.
- Generalises the ALU: XLEN-wide, sequential, with handshake, flush and W-variant support.

Parameters:
- XLEN, 64: datapath width; legal values 32 and 64.
- W_OPS, 1: enables the *W opcodes. Forced to 0 when XLEN=32.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush_i  in  1  pipeline flush; aborts any in-flight or held operation.
- in_valid_i  in  1  operation offered.
- in_ready_o  out  1  unit can accept; high only in IDLE.
- op_i  in  4  operation code (md_op_e).
- a_i  in  XLEN  rs1 value.
- b_i  in  XLEN  rs2 value.
- rd_i  in  5  destination register address, carried through.
- out_valid_o  out  1  result available.
- out_ready_i  in  1  consumer accepts result.
- result_o  out  XLEN  result.
- rd_o  out  5  destination address of the result.
- busy_o  out  1  high in CALC or DONE; drives the hazard stall.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE, counter=0.
  - out_valid_o=0, result_o=0, rd_o=0, busy_o=0, in_ready_o=1 once reset is released.
- States and transitions:
  - IDLE -> CALC on accept (in_valid_i & in_ready_o), normal path.
  - IDLE -> DONE on accept, fast path.
  - CALC -> DONE when the counter reaches N-1.
  - DONE -> IDLE on out_valid_o & out_ready_i.
- Operand capture at accept: a_i, b_i, op_i and rd_i are registered. Inputs are ignored outside IDLE.
- Operand width N:
  - N=32 for W ops: operands are the low 32 bits, signed or unsigned per op.
  - N=XLEN otherwise.
- Multiply:
  - Radix-2 shift-add on magnitudes, one bit per CALC cycle, 2N-bit product.
  - Sign is corrected in the DONE-entry cycle.
  - MUL returns the low XLEN bits.
  - MULH / MULHSU / MULHU return the high XLEN bits: signed×signed, signed×unsigned, unsigned×unsigned respectively.
  - MULW returns the low 32 bits, sign-extended.
- Divide:
  - Restoring division on magnitudes, one quotient bit per cycle.
  - Quotient sign = sign(a) xor sign(b); remainder sign = sign(a).
  - W ops sign-extend the 32-bit result to XLEN.
- Fast path (no CALC; out_valid_o in cycle T+1 after accept cycle T):
  - Divide by zero: quotient = all ones; remainder = dividend (N-bit, sign-extended for W ops).
  - Signed overflow (most-negative / -1): quotient = dividend; remainder = 0.
  - Illegal op_i: result = 0.
- Latency (normal path): out_valid_o rises in cycle T+1+N, i.e. T+65 for 64-bit ops and T+33 for W ops.
- Output hold: result_o, rd_o and out_valid_o stay stable while out_valid_o=1 and out_ready_i=0.
- Back-to-back: in_ready_o rises in the cycle after the output handshake. No accept occurs in the same cycle as the output handshake.
- Flush:
  - flush_i=1 forces state=IDLE and out_valid_o=0 on the next edge.
  - The flushed result is never presented.
  - Flush beats a simultaneous accept: the operation is dropped.
  - Flush during a DONE handshake: the handshake completes as seen by the consumer in that cycle; the unit still returns to IDLE.
- Reset mid-operation: immediate return to IDLE. No output is produced.

Decomposition:
- Package md_pkg holds:
  - md_op_e: MUL=0, MULH=1, MULHSU=2, MULHU=3, DIV=4, DIVU=5, REM=6, REMU=7, MULW=8, DIVW=9, DIVUW=10, REMW=11, REMUW=12; 13-15 illegal.
  - State enum md_state_e {IDLE, CALC, DONE}.
  - Helpers is_div, is_signed_a, is_signed_b, is_word.
- One sub-module, md_iter_core: a shared shift register / adder datapath performing one multiply or divide step per enable.

Test Plan:
- MUL a=7, b=0xFFFF_FFFF_FFFF_FFFD (-3) -> result 0xFFFF_FFFF_FFFF_FFEB, out_valid_o at T+65, rd_o equals rd_i.
- MULH a=b=0x8000_0000_0000_0000 -> 0x4000_0000_0000_0000; MULHU with the same operands -> 0x4000_0000_0000_0000; MULHSU -> 0xC000_0000_0000_0000.
- DIV 100/0 -> 0xFFFF_FFFF_FFFF_FFFF at T+1; REM 100/0 -> 100; DIV 0x8000_0000_0000_0000 / -1 -> 0x8000_0000_0000_0000; REM of the same -> 0.
- DIVW a=0xFFFF_FFFF_FFFF_FFF9, b=2 -> 0xFFFF_FFFF_FFFF_FFFD at T+33; REMW with the same operands -> 0xFFFF_FFFF_FFFF_FFFF.
- Backpressure: hold out_ready_i=0 for 10 cycles after out_valid_o -> result stable, in_ready_o=0, busy_o=1; release -> in_ready_o=1 on the next cycle.
- Flush at CALC cycle 20 -> out_valid_o never asserts, IDLE next cycle. Flush together with in_valid_i -> no accept. rst_n pulse mid-CALC -> all outputs return to reset values immediately.

Source files
------------

// File: rtl/md_pkg.sv
// Shared types and opcode decode helpers for the iterative multiply/divide unit.
package md_pkg;

  typedef enum logic [3:0] {
    OpMul    = 4'd0,
    OpMulh   = 4'd1,
    OpMulhsu = 4'd2,
    OpMulhu  = 4'd3,
    OpDiv    = 4'd4,
    OpDivu   = 4'd5,
    OpRem    = 4'd6,
    OpRemu   = 4'd7,
    OpMulw   = 4'd8,
    OpDivw   = 4'd9,
    OpDivuw  = 4'd10,
    OpRemw   = 4'd11,
    OpRemuw  = 4'd12
  } md_op_e;

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StDone
  } md_state_e;

  localparam int unsigned WordW = 32;

  function automatic logic is_legal(logic [3:0] op);
    return op <= 4'd12;
  endfunction

  function automatic logic is_div(logic [3:0] op);
    return op inside {OpDiv, OpDivu, OpRem, OpRemu, OpDivw, OpDivuw, OpRemw, OpRemuw};
  endfunction

  function automatic logic is_rem(logic [3:0] op);
    return op inside {OpRem, OpRemu, OpRemw, OpRemuw};
  endfunction

  function automatic logic is_word(logic [3:0] op);
    return op inside {OpMulw, OpDivw, OpDivuw, OpRemw, OpRemuw};
  endfunction

  function automatic logic is_signed_a(logic [3:0] op);
    return op inside {OpMul, OpMulh, OpMulhsu, OpDiv, OpRem, OpMulw, OpDivw, OpRemw};
  endfunction

  function automatic logic is_signed_b(logic [3:0] op);
    return op inside {OpMul, OpMulh, OpDiv, OpRem, OpMulw, OpDivw, OpRemw};
  endfunction

endpackage

// File: rtl/md_iter_core.sv
// Shared hi/lo shift-register datapath: one shift-add multiply step or one
// restoring-divide step per enable, operating on unsigned magnitudes.
module md_iter_core #(
  parameter int unsigned Width = 64
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic             step_i,
  input  logic             div_i,
  input  logic [Width-1:0] lo_init_i,
  input  logic [Width-1:0] operand_b_i,
  output logic [Width-1:0] hi_next_o,
  output logic [Width-1:0] lo_next_o
);

  logic [Width-1:0] hi_q, lo_q, b_q;
  logic [Width-1:0] addend, diff;
  logic [Width:0]   sum;
  logic             ge;

  always_comb begin
    addend = lo_q[0] ? b_q : {Width{1'b0}};
    sum    = {1'b0, hi_q} + {1'b0, addend};
    // Partial remainder is always < divisor, so the shifted value needs Width+1 bits
    // for the compare but the difference itself fits in Width bits.
    ge     = {hi_q, lo_q[Width-1]} >= {1'b0, b_q};
    diff   = {hi_q[Width-2:0], lo_q[Width-1]} - b_q;
    if (div_i) begin
      if (ge) begin
        hi_next_o = diff;
        lo_next_o = {lo_q[Width-2:0], 1'b1};
      end else begin
        hi_next_o = {hi_q[Width-2:0], lo_q[Width-1]};
        lo_next_o = {lo_q[Width-2:0], 1'b0};
      end
    end else begin
      hi_next_o = sum[Width:1];
      lo_next_o = {sum[0], lo_q[Width-1:1]};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hi_q <= '0;
      lo_q <= '0;
      b_q  <= '0;
    end else if (load_i) begin
      hi_q <= '0;
      lo_q <= lo_init_i;
      b_q  <= operand_b_i;
    end else if (step_i) begin
      hi_q <= hi_next_o;
      lo_q <= lo_next_o;
    end
  end

endmodule

// File: rtl/exe_muldiv.sv
// Iterative RV64M/RV32M multiply/divide execute unit with valid/ready handshake,
// flush, fast-path special cases and sign correction on DONE entry.
module exe_muldiv
  import md_pkg::*;
#(
  parameter int unsigned XLEN  = 64,
  parameter bit          W_OPS = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [3:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic [4:0]      rd_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [XLEN-1:0] result_o,
  output logic [4:0]      rd_o,
  output logic            busy_o
);

  localparam bit          WEn    = W_OPS && (XLEN == 64);
  localparam int unsigned CntW   = $clog2(XLEN);
  localparam int unsigned WShift = XLEN - WordW;

  function automatic logic [XLEN-1:0] sext_w(logic [XLEN-1:0] v);
    return XLEN'($signed(v[WordW-1:0]));
  endfunction

  function automatic logic [XLEN-1:0] zext_w(logic [XLEN-1:0] v);
    return XLEN'(v[WordW-1:0]);
  endfunction

  md_state_e       state_q;
  logic [CntW-1:0] cnt_q, cnt_last;
  logic [3:0]      op_q;
  logic            word_q, neg_q, out_valid_q;
  logic [XLEN-1:0] result_q;
  logic [4:0]      rd_q;

  logic            accept, word_in, legal_in, div_in, rem_in, sa, sb, fast_in, neg_in;
  logic [XLEN-1:0] a_ext, b_ext, a_mag, b_mag, lo_init, fast_res, min_val;
  logic [XLEN-1:0] hi_n, lo_n, quo, rem, calc_res;
  logic [2*XLEN-1:0] prod, prod_s;

  assign accept = in_valid_i && (state_q == StIdle) && !flush_i;

  always_comb begin
    word_in  = WEn && is_word(op_i);
    legal_in = is_legal(op_i) && (WEn || !is_word(op_i));
    div_in   = is_div(op_i);
    rem_in   = is_rem(op_i);
    a_ext    = a_i;
    b_ext    = b_i;
    min_val  = {1'b1, {(XLEN-1){1'b0}}};
    if (word_in) begin
      a_ext   = is_signed_a(op_i) ? sext_w(a_i) : zext_w(a_i);
      b_ext   = is_signed_b(op_i) ? sext_w(b_i) : zext_w(b_i);
      min_val = XLEN'($signed(32'h8000_0000));
    end
    sa      = is_signed_a(op_i) && a_ext[XLEN-1];
    sb      = is_signed_b(op_i) && b_ext[XLEN-1];
    a_mag   = sa ? -a_ext : a_ext;
    b_mag   = sb ? -b_ext : b_ext;
    neg_in  = rem_in ? sa : (sa ^ sb);
    // Word divides start with the dividend left-aligned so 32 steps consume it fully.
    lo_init = (div_in && word_in) ? (a_mag << WShift) : a_mag;

    fast_in  = 1'b1;
    fast_res = '0;
    if (!legal_in) begin
      fast_res = '0;
    end else if (div_in && (b_ext == '0)) begin
      fast_res = rem_in ? (word_in ? sext_w(a_i) : a_i) : '1;
    end else if (div_in && is_signed_a(op_i) && (a_ext == min_val) && (b_ext == '1)) begin
      fast_res = rem_in ? '0 : a_ext;
    end else begin
      fast_in = 1'b0;
    end
  end

  md_iter_core #(
    .Width(XLEN)
  ) u_core (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .load_i     (accept),
    .step_i     (state_q == StCalc),
    .div_i      (is_div(op_q)),
    .lo_init_i  (lo_init),
    .operand_b_i(b_mag),
    .hi_next_o  (hi_n),
    .lo_next_o  (lo_n)
  );

  always_comb begin
    prod = {hi_n, lo_n};
    // After only 32 shift-add steps the word product sits 32 bits up.
    if (word_q) prod = prod >> WShift;
    prod_s = neg_q ? -prod : prod;
    quo    = neg_q ? -lo_n : lo_n;
    rem    = neg_q ? -hi_n : hi_n;
    case (op_q)
      OpMul:                      calc_res = prod_s[XLEN-1:0];
      OpMulh, OpMulhsu, OpMulhu:  calc_res = prod_s[2*XLEN-1:XLEN];
      OpMulw:                     calc_res = sext_w(prod_s[XLEN-1:0]);
      OpDiv, OpDivu:              calc_res = quo;
      OpRem, OpRemu:              calc_res = rem;
      OpDivw, OpDivuw:            calc_res = sext_w(quo);
      OpRemw, OpRemuw:            calc_res = sext_w(rem);
      default:                    calc_res = '0;
    endcase
  end

  assign cnt_last = word_q ? CntW'(WordW - 1) : CntW'(XLEN - 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      op_q        <= '0;
      word_q      <= 1'b0;
      neg_q       <= 1'b0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      rd_q        <= '0;
    end else if (flush_i) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (in_valid_i) begin
            op_q   <= op_i;
            word_q <= word_in;
            neg_q  <= neg_in;
            rd_q   <= rd_i;
            cnt_q  <= '0;
            if (fast_in) begin
              result_q    <= fast_res;
              out_valid_q <= 1'b1;
              state_q     <= StDone;
            end else begin
              state_q <= StCalc;
            end
          end
        end
        StCalc: begin
          if (cnt_q == cnt_last) begin
            result_q    <= calc_res;
            out_valid_q <= 1'b1;
            state_q     <= StDone;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StDone: begin
          if (out_ready_i) begin
            out_valid_q <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign in_ready_o  = (state_q == StIdle);
  assign busy_o      = (state_q != StIdle);
  assign out_valid_o = out_valid_q;
  assign result_o    = result_q;
  assign rd_o        = rd_q;

endmodule

// File: tb/tb_exe_muldiv.sv
// Scoreboard bench for exe_muldiv: directed vectors, backpressure, flush and reset cases.
module tb_exe_muldiv;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush_i = 1'b0;
  logic        in_valid_i = 1'b0;
  logic        in_ready_o;
  logic [3:0]  op_i = '0;
  logic [63:0] a_i = '0;
  logic [63:0] b_i = '0;
  logic [4:0]  rd_i = '0;
  logic        out_valid_o;
  logic        out_ready_i = 1'b1;
  logic [63:0] result_o;
  logic [4:0]  rd_o;
  logic        busy_o;

  exe_muldiv #(
    .XLEN (64),
    .W_OPS(1'b1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush_i    (flush_i),
    .in_valid_i (in_valid_i),
    .in_ready_o (in_ready_o),
    .op_i       (op_i),
    .a_i        (a_i),
    .b_i        (b_i),
    .rd_i       (rd_i),
    .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i),
    .result_o   (result_o),
    .rd_o       (rd_o),
    .busy_o     (busy_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string       name;
    logic [63:0] res;
    logic [4:0]  rd;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%h want 0x%h", name, act, exp);
    end
  endtask

  // Monitor: records the cycle out_valid_o rises, compares on each output handshake.
  logic prev_v = 1'b0;
  int   rise_cyc = 0;
  always @(negedge clk) begin
    #1;
    if (out_valid_o && !prev_v) begin
      rise_cyc = cyc;
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_output: got result 0x%h rd %0d, want no output", result_o, rd_o);
      end
    end
    if (out_valid_o && out_ready_i && sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      chk({e.name, "_res"}, result_o, e.res);
      chk({e.name, "_rd"}, 64'(rd_o), 64'(e.rd));
      chk({e.name, "_lat"}, 64'(rise_cyc - e.acc), 64'(e.lat));
    end
    prev_v = out_valid_o;
  end

  task automatic issue(input string name, input logic [3:0] op, input logic [63:0] a,
                       input logic [63:0] b, input logic [4:0] rd, input logic [63:0] exp,
                       input int lat, input bit push);
    int   n;
    exp_t e;
    n = 0;
    @(negedge clk);
    while (!in_ready_o && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready_o) begin
      total++;
      bad++;
      $display("FAIL %s_ready_timeout: in_ready_o got 0 want 1", name);
    end else begin
      op_i       = op;
      a_i        = a;
      b_i        = b;
      rd_i       = rd;
      in_valid_i = 1'b1;
      if (push) begin
        e.name = name;
        e.res  = exp;
        e.rd   = rd;
        e.lat  = lat;
        e.acc  = cyc;
        sb_q.push_back(e);
      end
      @(negedge clk);
      in_valid_i = 1'b0;
    end
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((sb_q.size() != 0 || busy_o) && n < 600) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (sb_q.size() != 0 || busy_o) begin
      bad++;
      $display("FAIL %s_drain: pending=%0d busy=%0b want pending=0 busy=0", name, sb_q.size(),
               busy_o);
    end
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    chk("rst_valid_in_reset", 64'(out_valid_o), 64'd0);
    chk("rst_busy_in_reset", 64'(busy_o), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_valid", 64'(out_valid_o), 64'd0);
    chk("rst_result", result_o, 64'd0);
    chk("rst_rd", 64'(rd_o), 64'd0);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_ready", 64'(in_ready_o), 64'd1);

    issue("mul", 4'd0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 5'd5, 64'hFFFF_FFFF_FFFF_FFEB, 65, 1);
    issue("mulh", 4'd1, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 5'd6,
          64'h4000_0000_0000_0000, 65, 1);
    issue("mulhu", 4'd3, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 5'd7,
          64'h4000_0000_0000_0000, 65, 1);
    issue("mulhsu", 4'd2, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 5'd8,
          64'hC000_0000_0000_0000, 65, 1);
    issue("mulhu_ones", 4'd3, '1, '1, 5'd9, 64'hFFFF_FFFF_FFFF_FFFE, 65, 1);
    issue("div_zero", 4'd4, 64'd100, 64'd0, 5'd10, 64'hFFFF_FFFF_FFFF_FFFF, 1, 1);
    issue("rem_zero", 4'd6, 64'd100, 64'd0, 5'd11, 64'd100, 1, 1);
    issue("div_ovf", 4'd4, 64'h8000_0000_0000_0000, '1, 5'd12, 64'h8000_0000_0000_0000, 1, 1);
    issue("rem_ovf", 4'd6, 64'h8000_0000_0000_0000, '1, 5'd13, 64'd0, 1, 1);
    issue("divw", 4'd9, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd14, 64'hFFFF_FFFF_FFFF_FFFD, 33, 1);
    issue("remw", 4'd11, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd15, 64'hFFFF_FFFF_FFFF_FFFF, 33, 1);
    issue("divu", 4'd5, 64'd100, 64'd7, 5'd16, 64'd14, 65, 1);
    issue("remu", 4'd7, 64'd100, 64'd7, 5'd17, 64'd2, 65, 1);
    issue("div_neg", 4'd4, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 5'd18, 64'hFFFF_FFFF_FFFF_FFF2, 65, 1);
    issue("rem_neg", 4'd6, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 5'd19, 64'hFFFF_FFFF_FFFF_FFFE, 65, 1);
    issue("mulw", 4'd8, 64'h0000_0001_0000_0003, 64'h7FFF_FFFF, 5'd20, 64'h0000_0000_7FFF_FFFD,
          33, 1);
    issue("divuw", 4'd10, 64'hFFFF_FFFF, 64'd2, 5'd21, 64'h0000_0000_7FFF_FFFF, 33, 1);
    issue("remuw", 4'd12, 64'hFFFF_FFFF, 64'd2, 5'd22, 64'd1, 33, 1);
    issue("illegal", 4'd13, 64'd5, 64'd6, 5'd23, 64'd0, 1, 1);
    drain("vectors");

    // Backpressure: result must hold while the consumer stalls.
    out_ready_i = 1'b0;
    issue("bp", 4'd5, 64'd100, 64'd7, 5'd9, 64'd14, 65, 1);
    n = 0;
    while (!out_valid_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("bp_valid_seen", 64'(out_valid_o), 64'd1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_hold_res", result_o, 64'd14);
      chk("bp_hold_valid", 64'(out_valid_o), 64'd1);
      chk("bp_hold_ready", 64'(in_ready_o), 64'd0);
      chk("bp_hold_busy", 64'(busy_o), 64'd1);
    end
    out_ready_i = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", 64'(in_ready_o), 64'd1);
    chk("bp_release_busy", 64'(busy_o), 64'd0);
    chk("bp_release_valid", 64'(out_valid_o), 64'd0);

    // Flush at CALC cycle 20.
    issue("fl", 4'd0, 64'd5, 64'd6, 5'd3, 64'd0, 0, 0);
    repeat (20) @(negedge clk);
    chk("fl_busy_before", 64'(busy_o), 64'd1);
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    chk("fl_ready", 64'(in_ready_o), 64'd1);
    chk("fl_busy", 64'(busy_o), 64'd0);
    chk("fl_valid", 64'(out_valid_o), 64'd0);
    repeat (80) @(negedge clk);
    chk("fl_result_untouched", result_o, 64'd14);

    // Flush together with an offered operation: nothing is accepted.
    op_i       = 4'd5;
    a_i        = 64'd9;
    b_i        = 64'd3;
    rd_i       = 5'd4;
    in_valid_i = 1'b1;
    flush_i    = 1'b1;
    @(negedge clk);
    in_valid_i = 1'b0;
    flush_i    = 1'b0;
    chk("flacc_busy", 64'(busy_o), 64'd0);
    chk("flacc_ready", 64'(in_ready_o), 64'd1);
    repeat (70) @(negedge clk);

    // Asynchronous reset mid-CALC.
    issue("rs", 4'd5, 64'd1000, 64'd3, 5'd17, 64'd0, 0, 0);
    repeat (10) @(negedge clk);
    chk("rs_busy_before", 64'(busy_o), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("rs_valid", 64'(out_valid_o), 64'd0);
    chk("rs_result", result_o, 64'd0);
    chk("rs_rd", 64'(rd_o), 64'd0);
    chk("rs_busy", 64'(busy_o), 64'd0);
    chk("rs_ready", 64'(in_ready_o), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;

    issue("mul_after_rst", 4'd0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 5'd25, 64'hFFFF_FFFF_FFFF_FFEB,
          65, 1);
    drain("final");
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
